// File: rtl/pipe_word_serializer.sv
// pipe_word_serializer
//   Takes one 144-bit message (16-bit header + 128-bit payload) from an
//   upstream pipe and emits it to a word sink as 32-bit words. The header
//   word comes first, then the payload words low word first. The payload
//   length comes from the header and is clamped to MAX_WORDS.
//
// Ports
//   CLK            clock; all state changes on the rising edge
//   RST            synchronous active-high reset
//   pipe_enq__ENA  upstream delivers a message this cycle (only while RDY)
//   pipe_enq_v     message: [143:128] header, [127:0] payload
//   pipe_enq__RDY  block is idle and can accept a message
//   out_enq__ENA   a word transfers to the sink this cycle
//   out_enq_v      word data
//   out_enq_last   current word is the final word of its message
//   out_enq__RDY   sink can take a word this cycle
//   msg_count      number of fully emitted messages (wraps)
//   len_err        sticky: some header length exceeded MAX_WORDS
module pipe_word_serializer #(
   parameter int MAX_WORDS = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         pipe_enq__ENA,
   input  logic [143:0] pipe_enq_v,
   output logic         pipe_enq__RDY,
   output logic         out_enq__ENA,
   output logic [31:0]  out_enq_v,
   output logic         out_enq_last,
   input  logic         out_enq__RDY,
   output logic [15:0]  msg_count,
   output logic         len_err
);

   localparam logic [7:0] MAXW = 8'(MAX_WORDS);

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t        state;
   logic [143:0]  hold;
   logic [1:0]    idx;

   logic [15:0]   hdr;
   logic [127:0]  payload;
   logic [7:0]    len;
   logic [7:0]    clamp;

   assign hdr     = hold[143:128];
   assign payload = hold[127:0];
   assign len     = hdr[7:0];
   assign clamp   = (len > MAXW) ? MAXW : len;

   assign pipe_enq__RDY = (state == IDLE);
   assign out_enq__ENA  = (state != IDLE) && out_enq__RDY;

   // Word and last flag are pure functions of the registered state, so they
   // stay stable for as long as the sink stalls.
   always_comb begin
      out_enq_v    = 32'h0;
      out_enq_last = 1'b0;
      case (state)
         HDR: begin
            out_enq_v    = {16'h0000, hdr[15:8], clamp};
            out_enq_last = (clamp == 8'd0);
         end
         DATA: begin
            out_enq_v    = payload[{idx, 5'b0} +: 32];
            out_enq_last = ({6'b0, idx} == (clamp - 8'd1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         idx       <= 2'd0;
         msg_count <= 16'd0;
         len_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pipe_enq__ENA) begin
                  hold  <= pipe_enq_v;
                  state <= HDR;
               end
            end
            HDR: begin
               if (out_enq__RDY) begin
                  if (len > MAXW) len_err <= 1'b1;
                  if (clamp == 8'd0) begin
                     state     <= IDLE;
                     msg_count <= msg_count + 16'd1;
                  end else begin
                     state <= DATA;
                     idx   <= 2'd0;
                  end
               end
            end
            DATA: begin
               if (out_enq__RDY) begin
                  if (out_enq_last) begin
                     state     <= IDLE;
                     msg_count <= msg_count + 16'd1;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_word_serializer.sv
// tb_pipe_word_serializer
//   Directed bench for pipe_word_serializer. Inputs change 1 time unit after
//   the rising edge; outputs are checked at the same point, i.e. they reflect
//   the state registered by the preceding edge.
module tb_pipe_word_serializer;

   logic         clk = 1'b0;
   logic         rst;
   logic         enq_ena;
   logic [143:0] enq_v;
   logic         enq_rdy;
   logic         out_ena;
   logic [31:0]  out_v;
   logic         out_last;
   logic         out_rdy;
   logic [15:0]  msg_count;
   logic         len_err;

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] P1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
   localparam logic [127:0] P2 = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
   localparam logic [127:0] P3 = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

   pipe_word_serializer #(.MAX_WORDS(4)) dut (
      .CLK           (clk),
      .RST           (rst),
      .pipe_enq__ENA (enq_ena),
      .pipe_enq_v    (enq_v),
      .pipe_enq__RDY (enq_rdy),
      .out_enq__ENA  (out_ena),
      .out_enq_v     (out_v),
      .out_enq_last  (out_last),
      .out_enq__RDY  (out_rdy),
      .msg_count     (msg_count),
      .len_err       (len_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a message for one accept edge.
   task automatic send(input logic [15:0] hdr, input logic [127:0] pl);
      enq_ena = 1'b1;
      enq_v   = {hdr, pl};
      step();
      enq_ena = 1'b0;
      enq_v   = '0;
   endtask

   // Check the word currently offered, then let it transfer.
   task automatic expect_word(input string tag, input logic [31:0] w, input logic l);
      chk({tag, "_ena"},  {31'b0, out_ena},  32'd1);
      chk({tag, "_v"},    out_v,             w);
      chk({tag, "_last"}, {31'b0, out_last}, {31'b0, l});
      step();
   endtask

   initial begin
      rst = 1'b1; enq_ena = 1'b0; enq_v = '0; out_rdy = 1'b1;
      step(); step();
      rst = 1'b0;
      chk("rst_rdy",   {31'b0, enq_rdy},  32'd1);
      chk("rst_ena",   {31'b0, out_ena},  32'd0);
      chk("rst_v",     out_v,             32'd0);
      chk("rst_last",  {31'b0, out_last}, 32'd0);
      chk("rst_cnt",   {16'b0, msg_count}, 32'd0);
      chk("rst_lerr",  {31'b0, len_err},  32'd0);

      // Four-word message, sink always ready.
      send(16'h0504, P1);
      chk("m1_rdy_busy", {31'b0, enq_rdy}, 32'd0);
      expect_word("m1_h",  32'h0000_0504, 1'b0);
      expect_word("m1_w0", 32'h1111_1111, 1'b0);
      expect_word("m1_w1", 32'h2222_2222, 1'b0);
      expect_word("m1_w2", 32'h3333_3333, 1'b0);
      expect_word("m1_w3", 32'h4444_4444, 1'b1);
      chk("m1_rdy", {31'b0, enq_rdy}, 32'd1);
      chk("m1_ena", {31'b0, out_ena}, 32'd0);
      chk("m1_cnt", {16'b0, msg_count}, 32'd1);

      // Zero-length message: header only.
      send(16'h0700, P1);
      expect_word("m2_h", 32'h0000_0700, 1'b1);
      chk("m2_rdy", {31'b0, enq_rdy}, 32'd1);
      chk("m2_ena", {31'b0, out_ena}, 32'd0);
      chk("m2_cnt", {16'b0, msg_count}, 32'd2);

      // Over-long length clamps to 4 and sets the sticky error.
      send(16'h0209, P2);
      chk("m3_lerr_pre", {31'b0, len_err}, 32'd0);
      expect_word("m3_h",  32'h0000_0204, 1'b0);
      chk("m3_lerr", {31'b0, len_err}, 32'd1);
      expect_word("m3_w0", 32'hAAAA_AAAA, 1'b0);
      expect_word("m3_w1", 32'hBBBB_BBBB, 1'b0);
      expect_word("m3_w2", 32'hCCCC_CCCC, 1'b0);
      expect_word("m3_w3", 32'hDDDD_DDDD, 1'b1);
      chk("m3_cnt", {16'b0, msg_count}, 32'd3);

      // Length 2 with a 3-cycle stall on the second payload word.
      send(16'h0102, P3);
      expect_word("m4_h",  32'h0000_0102, 1'b0);
      expect_word("m4_w0", 32'h5555_5555, 1'b0);
      for (int i = 0; i < 3; i++) begin
         out_rdy = 1'b0;
         #1;
         chk($sformatf("m4_stall%0d_ena", i), {31'b0, out_ena}, 32'd0);
         chk($sformatf("m4_stall%0d_v", i),   out_v,            32'h6666_6666);
         step();
      end
      out_rdy = 1'b1;
      #1;
      expect_word("m4_w1", 32'h6666_6666, 1'b1);
      chk("m4_idle", {31'b0, out_ena}, 32'd0);
      chk("m4_cnt",  {16'b0, msg_count}, 32'd4);
      chk("m4_lerr_sticky", {31'b0, len_err}, 32'd1);

      // Reset during DATA idx=1 discards the message.
      send(16'h0304, P3);
      expect_word("m5_h",  32'h0000_0304, 1'b0);
      expect_word("m5_w0", 32'h5555_5555, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("m5_rdy",  {31'b0, enq_rdy}, 32'd1);
      chk("m5_ena",  {31'b0, out_ena}, 32'd0);
      chk("m5_v",    out_v, 32'd0);
      chk("m5_cnt",  {16'b0, msg_count}, 32'd0);
      chk("m5_lerr", {31'b0, len_err}, 32'd0);
      step();
      chk("m5_quiet", {31'b0, out_ena}, 32'd0);

      // Clean message after reset.
      send(16'h0504, P1);
      expect_word("m6_h",  32'h0000_0504, 1'b0);
      expect_word("m6_w0", 32'h1111_1111, 1'b0);
      expect_word("m6_w1", 32'h2222_2222, 1'b0);
      expect_word("m6_w2", 32'h3333_3333, 1'b0);
      expect_word("m6_w3", 32'h4444_4444, 1'b1);
      chk("m6_cnt", {16'b0, msg_count}, 32'd1);

      // Back-to-back zero-length messages until the counter wraps.
      for (int i = 0; i < 65534; i++) begin
         enq_ena = 1'b1;
         enq_v   = {16'h0700, 128'h0};
         step();
         enq_ena = 1'b0;
         step();
      end
      chk("wrap_ffff", {16'b0, msg_count}, 32'h0000_FFFF);
      enq_ena = 1'b1;
      enq_v   = {16'h0700, 128'h0};
      step();
      enq_ena = 1'b0;
      step();
      chk("wrap_zero", {16'b0, msg_count}, 32'd0);
      chk("wrap_rdy",  {31'b0, enq_rdy}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
